fp_stream_accumulator: RTL
==========================

Name: fp_stream_accumulator

Overview:
- Sequential controller that reduces a valid/ready stream of float_point_num beats (float_types_pkg: sign 1, exp 8, mant 23) to a single sum.
- Sits directly around comb_fp_summator. It drives the summator's operand and valid inputs, and registers the summator's answer and status back into a running accumulator.
- The result is emitted on a valid/ready output with a beat count and a sticky NaN/Inf flag.

Parameters:
- MAX_LEN, 256: maximum beats counted per packet; count saturates here.
- CNT_W, $clog2(MAX_LEN+1): width of the beat counter (derived; do not override).

Ports:
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  asynchronous active-low reset
- s_data_i  in  32  input beat (float_point_num)
- s_valid_i  in  1  input beat valid
- s_last_i  in  1  marks final beat of packet
- s_ready_o  out  1  input beat accepted when s_valid_i && s_ready_o
- sum_a_o  out  32  summator operand a (accumulator)
- sum_b_o  out  32  summator operand b (held beat)
- sum_vld_o  out  1  summator valid
- sum_res_i  in  32  summator answer_o
- sum_status_i  in  1  summator answer_status_o (1 = NaN/Inf)
- m_data_o  out  32  packet sum
- m_status_o  out  1  sticky NaN/Inf or count overflow
- m_count_o  out  CNT_W  beats in packet, saturating
- m_valid_o  out  1  result valid
- m_ready_i  in  1  result accepted

Behaviour:
- Reset (asynchronous, any state, including mid-packet): state = IDLE; acc, op, m_data_o, m_count_o, m_status_o, m_valid_o, sum_vld_o = 0; sum_a_o and sum_b_o = 0. The partial packet is discarded.
- Zero beat: exp == 0 && mant == 0, either sign. Acc-is-zero: the accumulator holds a zero beat.
- Inf/NaN beat: exp == 8'hFF.
- IDLE, s_ready_o = 1:
  - On handshake: acc <= beat; count <= 1; status <= (beat exp == 8'hFF).
  - Next state is DONE if s_last_i, else ACCUM.
- ACCUM, s_ready_o = 1:
  - On handshake: count <= sat(count+1); op <= beat; last_q <= s_last_i.
  - If the beat is zero: no add. Acc unchanged. Go to DONE if last, else stay in ACCUM.
  - Else if acc is zero: acc <= beat; status |= (beat exp == 8'hFF). No add. Go to DONE if last, else stay in ACCUM.
  - Else go to ADD.
- ADD, s_ready_o = 0, one cycle:
  - Drive sum_vld_o = 1, sum_a_o = acc, sum_b_o = op.
  - At clock edge: acc <= sum_res_i; status <= status | sum_status_i.
  - Next state is DONE if last_q, else ACCUM.
- DONE, s_ready_o = 0:
  - m_valid_o = 1; m_data_o = acc; m_count_o = count; m_status_o = status | ovf.
  - Outputs are held stable until m_ready_i.
  - On handshake: go to IDLE and clear m_valid_o the next cycle.
- Throughput: a non-trivial beat costs 2 cycles (accept, then ADD). A skipped beat costs 1 cycle.
- Latency: result valid 1 cycle after the last ADD, or 1 cycle after accepting a last beat that needed no add.
- Count saturation: count stops at MAX_LEN. A beat accepted while count == MAX_LEN sets sticky ovf; accumulation continues.
- Outside ADD: sum_vld_o = 0 and sum_a_o/sum_b_o keep their last driven values (no toggling).
- Single-beat packet (first beat with last): result = that beat, count 1, no summator activity.
- s_last_i is sampled only on handshake. s_data_i is ignored when not handshaking.

Optional Feature:
- Macro: FP_ACC_NAN_ABORT_EN.
- Defined: once status is set, subsequent beats of the packet are accepted and counted but never enter ADD. Acc is frozen; the packet drains at 1 beat/cycle until last.
- Undefined: beats continue through ADD regardless of status.

Test Plan:
- Bench drives sum_res_i/sum_status_i from an ideal truncating IEEE-754 adder model.
- Packet {0x3F800000, 0x40000000, last 0x3F000000} (1.0, 2.0, 0.5):
  - Two ADD cycles are observed.
  - Response: m_data_o = 0x40600000 (3.5), m_count_o = 3, m_status_o = 0.
- Single beat, last 0xC0400000:
  - Response: m_valid_o 1 cycle later, m_data_o = 0xC0400000, count 1, sum_vld_o never asserted.
- Packet {0x00000000, 0x3FC00000, last 0x80000000}:
  - No ADD occurs.
  - Response: m_data_o = 0x3FC00000, count 3.
- Packet {0x3F800000, 0x7F800000, last 0x3F800000}:
  - Response: m_status_o = 1 and count 3.
  - With FP_ACC_NAN_ABORT_EN, only one ADD cycle occurs.
- Hold m_ready_i = 0 for 5 cycles in DONE:
  - m_data_o, m_count_o, m_status_o stable; s_ready_o = 0.
  - Release: IDLE next cycle.
- Assert rst_ni = 0 during ADD of a 4-beat packet:
  - Outputs zero immediately (asynchronous).
  - The next packet {last 0x3F800000} returns 0x3F800000, count 1.

Source files
------------

// File: rtl/fp_stream_accumulator.sv
// fp_stream_accumulator: folds a float beat stream into one sum through an external comb_fp_summator.
// Define FP_ACC_NAN_ABORT_EN to freeze the sum once NaN/Inf is seen; the rest of the packet then drains without adds.
module fp_stream_accumulator #(
    parameter int MAX_LEN = 256,
    localparam int CNT_W = $clog2(MAX_LEN + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [31:0]      s_data_i,
    input  logic             s_valid_i,
    input  logic             s_last_i,
    output logic             s_ready_o,
    output logic [31:0]      sum_a_o,
    output logic [31:0]      sum_b_o,
    output logic             sum_vld_o,
    input  logic [31:0]      sum_res_i,
    input  logic             sum_status_i,
    output logic [31:0]      m_data_o,
    output logic             m_status_o,
    output logic [CNT_W-1:0] m_count_o,
    output logic             m_valid_o,
    input  logic             m_ready_i
);
    typedef enum logic [1:0] {IDLE, ACCUM, ADD, DONE} state_t;
    state_t           state_q, state_d;
    logic [31:0]      acc_q, acc_d, sum_a_q, sum_a_d, sum_b_q, sum_b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             status_q, status_d, ovf_q, ovf_d, last_q, last_d;
    logic             hs, beat_zero, beat_inf, acc_zero, cnt_max, frozen;
`ifdef FP_ACC_NAN_ABORT_EN
    assign frozen = status_q;
`else
    assign frozen = 1'b0;
`endif
    assign s_ready_o  = state_q == IDLE || state_q == ACCUM;
    assign hs         = s_valid_i && s_ready_o;
    assign beat_zero  = s_data_i[30:0] == 31'd0;
    assign beat_inf   = &s_data_i[30:23];
    assign acc_zero   = acc_q[30:0] == 31'd0;
    assign cnt_max    = cnt_q == CNT_W'(MAX_LEN);
    assign sum_vld_o  = state_q == ADD;
    assign sum_a_o    = sum_a_q;
    assign sum_b_o    = sum_b_q;
    assign m_valid_o  = state_q == DONE;
    assign m_data_o   = acc_q;
    assign m_count_o  = cnt_q;
    assign m_status_o = status_q | ovf_q;
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        status_d = status_q;
        ovf_d    = ovf_q;
        last_d   = last_q;
        sum_a_d  = sum_a_q;
        sum_b_d  = sum_b_q;
        case (state_q)
            IDLE: if (hs) begin
                acc_d    = s_data_i;
                cnt_d    = CNT_W'(1);
                status_d = beat_inf;
                ovf_d    = 1'b0;
                state_d  = s_last_i ? DONE : ACCUM;
            end
            ACCUM: if (hs) begin
                cnt_d   = cnt_max ? cnt_q : cnt_q + CNT_W'(1);
                ovf_d   = ovf_q | cnt_max;
                last_d  = s_last_i;
                state_d = s_last_i ? DONE : ACCUM;
                // Zero beats and beats landing on a zero accumulator never need the summator
                if (!beat_zero && !frozen) begin
                    if (acc_zero) begin
                        acc_d    = s_data_i;
                        status_d = status_q | beat_inf;
                    end else begin
                        state_d = ADD;
                        sum_a_d = acc_q;
                        sum_b_d = s_data_i;
                    end
                end
            end
            ADD: begin
                acc_d    = sum_res_i;
                status_d = status_q | sum_status_i;
                state_d  = last_q ? DONE : ACCUM;
            end
            DONE: if (m_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            status_q <= 1'b0;
            ovf_q    <= 1'b0;
            last_q   <= 1'b0;
            sum_a_q  <= '0;
            sum_b_q  <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            status_q <= status_d;
            ovf_q    <= ovf_d;
            last_q   <= last_d;
            sum_a_q  <= sum_a_d;
            sum_b_q  <= sum_b_d;
        end
    end
endmodule
